// File: rtl/vga_ctrl.sv
// ---------------------------------------------------------------------------
// vga_ctrl : 640x480@60 Hz VGA timing controller (25 MHz pixel clock).
//
// Generates scan coordinates for a pixel source and takes that source's pixel
// PIX_LAT cycles later. It drives blanked 4:4:4 RGB together with HS/VS. All
// pin outputs are aligned to each other, PIX_LAT+1 cycles after x_pos/y_pos.
//
// Ports
//   vga_clk     in   pixel clock, rising edge
//   vga_rst     in   synchronous active-high reset
//   pixel_data  in   [11:8] blue, [7:4] green, [3:0] red
//   x_pos       out  horizontal counter (registered)
//   y_pos       out  vertical counter (registered)
//   frame_start out  high while counters read (0,0)
//   video_on    out  active-region flag, aligned with RGB
//   hs, vs      out  active-low syncs, aligned with RGB
//   vga_r/g/b   out  colour, zero outside the active region
// ---------------------------------------------------------------------------
module vga_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_LAT  = 1     // legal range 1..4
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [11:0] pixel_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        frame_start,
    output logic        video_on,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic               run_q, run_d;
    logic [9:0]         h_q, h_d;
    logic [9:0]         v_q, v_d;
    logic               frame_start_q, frame_start_d;
    logic               act0, hs0, vs0;
    logic               h_wrap;
    logic [PIX_LAT-1:0] act_sr_q, act_sr_d;
    logic [PIX_LAT-1:0] hs_sr_q, hs_sr_d;
    logic [PIX_LAT-1:0] vs_sr_q, vs_sr_d;
    logic               video_on_q, video_on_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [3:0]         r_q, r_d;
    logic [3:0]         g_q, g_d;
    logic [3:0]         b_q, b_d;

    // The (0,0) seen while reset is held is not a real scan position: run_q
    // holds the counters at (0,0) for one more edge, so the first real cycle
    // after release is (0,0) with frame_start. That held cycle also feeds
    // blanking, not pixel (0,0), into the alignment pipeline.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        run_d  = 1'b1;
        if (!run_q) begin
            h_d = '0;
            v_d = '0;
        end else begin
            h_d = h_wrap ? '0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                v_d = v_q;
            end
        end
        frame_start_d = (h_d == '0) && (v_d == '0);

        act0 = run_q && (h_q < H_ACT) && (v_q < V_ACT);
        hs0  = !(run_q && (h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vs0  = !(run_q && (v_q >= VS_FIRST) && (v_q <= VS_LAST));

        act_sr_d[0] = act0;
        hs_sr_d[0]  = hs0;
        vs_sr_d[0]  = vs0;
        for (int unsigned i = 1; i < PIX_LAT; i++) begin
            act_sr_d[i] = act_sr_q[i-1];
            hs_sr_d[i]  = hs_sr_q[i-1];
            vs_sr_d[i]  = vs_sr_q[i-1];
        end

        video_on_d = act_sr_q[PIX_LAT-1];
        hs_d       = hs_sr_q[PIX_LAT-1];
        vs_d       = vs_sr_q[PIX_LAT-1];
        r_d        = video_on_d ? pixel_data[3:0]  : '0;
        g_d        = video_on_d ? pixel_data[7:4]  : '0;
        b_d        = video_on_d ? pixel_data[11:8] : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            run_q         <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
            act_sr_q      <= '0;
            hs_sr_q       <= '1;
            vs_sr_q       <= '1;
            video_on_q    <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            run_q         <= run_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
            act_sr_q      <= act_sr_d;
            hs_sr_q       <= hs_sr_d;
            vs_sr_q       <= vs_sr_d;
            video_on_q    <= video_on_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
        end
    end

    assign x_pos       = h_q;
    assign y_pos       = v_q;
    assign frame_start = frame_start_q;
    assign video_on    = video_on_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_ctrl : self-checking bench for vga_ctrl.
// Instance 0 uses full 640x480 timing with PIX_LAT=1 (line-level behaviour).
// Instance 1 uses a tiny 30x15 raster with PIX_LAT=3 so that whole frames,
// frame wrap and vertical sync fit in a short run.
// Expected values come from scan position arithmetic (pos -> h,v) and a
// per-cycle log of what the bench itself drove.
// ---------------------------------------------------------------------------
module tb_vga_ctrl;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, lat;
    } cfg_t;

    typedef struct {
        bit act;
        bit hsy;
        bit vsy;
        int h;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pix [2];
    logic [9:0]  xp  [2];
    logic [9:0]  yp  [2];
    logic        fs  [2];
    logic        vo  [2];
    logic        hsn [2];
    logic        vsn [2];
    logic [3:0]  rr  [2];
    logic [3:0]  gg  [2];
    logic [3:0]  bb  [2];

    always #20 clk = ~clk;

    vga_ctrl #(.PIX_LAT(1)) u_full (
        .vga_clk(clk), .vga_rst(rst), .pixel_data(pix[0]),
        .x_pos(xp[0]), .y_pos(yp[0]), .frame_start(fs[0]), .video_on(vo[0]),
        .hs(hsn[0]), .vs(vsn[0]), .vga_r(rr[0]), .vga_g(gg[0]), .vga_b(bb[0])
    );

    vga_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIX_LAT(3)
    ) u_tiny (
        .vga_clk(clk), .vga_rst(rst), .pixel_data(pix[1]),
        .x_pos(xp[1]), .y_pos(yp[1]), .frame_start(fs[1]), .video_on(vo[1]),
        .hs(hsn[1]), .vs(vsn[1]), .vga_r(rr[1]), .vga_g(gg[1]), .vga_b(bb[1])
    );

    cfg_t        cfg [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pos [2];
    int          r_last [2];
    rec_t        rlog [2][16];
    logic [11:0] plog [2][16];
    int          mlog [16];
    logic [9:0]  xs [2][5];
    int          mode;          // 0 random, 1 coordinate source, 2 constant
    logic [11:0] cval;
    int          trk_prev [4];
    int          trk_run [4];
    int          trk_edge [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_cycle(input int k, input bit rs);
        int   ht, vt, h, v, src;
        rec_t rc, e;
        logic [11:0] p;
        ht = cfg[k].ha + cfg[k].hf + cfg[k].hs + cfg[k].hb;
        vt = cfg[k].va + cfg[k].vf + cfg[k].vs + cfg[k].vb;
        if (rs) begin
            pos[k]    = -1;
            r_last[k] = cyc;
        end else begin
            pos[k] = (pos[k] < 0) ? 0 : (pos[k] + 1) % (ht * vt);
        end
        h = (pos[k] < 0) ? 0 : pos[k] % ht;
        v = (pos[k] < 0) ? 0 : pos[k] / ht;
        rc.act = (pos[k] >= 0) && (h < cfg[k].ha) && (v < cfg[k].va);
        rc.hsy = !((pos[k] >= 0) && (h >= cfg[k].ha + cfg[k].hf) && (h < cfg[k].ha + cfg[k].hf + cfg[k].hs));
        rc.vsy = !((pos[k] >= 0) && (v >= cfg[k].va + cfg[k].vf) && (v < cfg[k].va + cfg[k].vf + cfg[k].vs));
        rc.h   = h;
        rlog[k][cyc % 16] = rc;
        check($sformatf("pos%0d", k), {xp[k], yp[k], fs[k]}, {10'(h), 10'(v), pos[k] == 0});

        // pins show the position from LAT+1 cycles ago with last cycle's pixel
        src = cyc - 1 - cfg[k].lat;
        if (src < r_last[k]) begin
            e.act = 1'b0; e.hsy = 1'b1; e.vsy = 1'b1; e.h = 0;
        end else begin
            e = rlog[k][src % 16];
        end
        if (!e.act)                          p = '0;
        else if (mlog[(cyc - 1) % 16] == 1)  p = {2'b00, 10'(e.h)};
        else                                 p = plog[k][(cyc - 1) % 16];
        check($sformatf("pins%0d", k), {vo[k], hsn[k], vsn[k], rr[k], gg[k], bb[k]},
              {e.act, e.hsy, e.vsy, p[3:0], p[7:4], p[11:8]});
    endtask

    // Width / period of an asserted level, measured between resets.
    task automatic track(input int id, input string tag, input bit asserted,
                         input int want_w, input int want_p, input bit rs);
        if (rs) begin
            trk_run[id]  = -1;
            trk_edge[id] = -1;
        end else begin
            if (asserted && trk_prev[id] == 0) begin
                if (trk_edge[id] >= 0) check({tag, "_period"}, cyc - trk_edge[id], want_p);
                trk_edge[id] = cyc;
                trk_run[id]  = 0;
            end
            if (asserted && trk_run[id] >= 0) trk_run[id]++;
            if (!asserted && trk_prev[id] != 0 && trk_run[id] >= 0) begin
                check({tag, "_width"}, trk_run[id], want_w);
                trk_run[id] = -1;
            end
        end
        trk_prev[id] = asserted ? 1 : 0;
    endtask

    task automatic tick();
        bit rs;
        rs = rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) model_cycle(k, rs);
        track(0, "hs_full",  !hsn[0], 96,  800, rs);
        track(1, "vo_full",  vo[0],   640, 800, rs);
        track(2, "vs_tiny",  !vsn[1], 60,  450, rs);
        track(3, "fs_tiny",  fs[1],   1,   450, rs);
        for (int k = 0; k < 2; k++) begin
            for (int j = 4; j > 0; j--) xs[k][j] = xs[k][j-1];
            xs[k][0] = xp[k];
            if (mode == 0)      pix[k] = 12'($urandom);
            else if (mode == 1) pix[k] = {2'b00, xs[k][cfg[k].lat]};
            else                pix[k] = cval;
            plog[k][cyc % 16] = pix[k];
        end
        mlog[cyc % 16] = mode;
    endtask

    initial begin
        cfg[0] = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, lat: 1};
        cfg[1] = '{ha: 16,  hf: 4,  hs: 6,  hb: 4,  va: 8,   vf: 2,  vs: 2, vb: 3,  lat: 3};
        mode   = 2;
        cval   = 12'hFFF;
        pix[0] = cval;
        pix[1] = cval;
        rst    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        cval = 12'h3A5;
        repeat (2400) tick();
        mode = 1;
        repeat (2400) tick();
        mode = 0;
        repeat (1600) tick();

        // single-cycle reset landing mid-line at x_pos=300
        mode = 2;
        for (int i = 0; i < 900 && xp[0] != 10'd300; i++) tick();
        check("find_x300", xp[0], 300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (1200) tick();

        for (int s = 0; s < 6; s++) begin
            mode = int'($urandom_range(0, 2));
            cval = 12'($urandom);
            repeat ($urandom_range(200, 3000)) tick();
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) tick();
            rst = 1'b0;
        end
        repeat (1000) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
VGA timing controller for 640x480@60 Hz, clocked at the 25 MHz pixel clock. It generates the scan coordinates x_pos/y_pos consumed by the pixel source (test pattern, image ROM, etc.). It accepts that source's 12-bit pixel_data a fixed number of cycles later. It then drives the board's 4:4:4 RGB and HS/VS pins with blanking applied and all outputs mutually aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
PIX_LAT, 1, pixel-source latency in cycles from x_pos/y_pos to pixel_data; legal range 1..4

Ports:
vga_clk  in  1  pixel clock; all logic on its rising edge
vga_rst  in  1  synchronous, active-high reset
pixel_data  in  12  pixel from source: [11:8] blue, [7:4] green, [3:0] red
x_pos  out  10  current horizontal count, registered
y_pos  out  10  current vertical count, registered
frame_start  out  1  high for the one cycle in which x_pos=0 and y_pos=0
video_on  out  1  active-region flag, aligned with the RGB pins
hs  out  1  horizontal sync, active low, aligned with RGB
vs  out  1  vertical sync, active low, aligned with RGB
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800; V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP=525.
- Horizontal region order by h count: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical region order by v count: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Counters:
  - h increments every cycle and wraps 799->0.
  - v increments only on an h wrap. When h wraps and v=524, v wraps to 0 in the same cycle.
  - x_pos and y_pos are the counter registers themselves. They are valid in every region; the source ignores them outside the active region.
- frame_start: registered; high exactly when the counters read (0,0), including the first cycle after reset release.
- Stage-0 flags, decoded from the counters:
  - act0 = (h<H_ACTIVE)&&(v<V_ACTIVE)
  - hs0 = !(656<=h<=751)
  - vs0 = !(490<=v<=491)
- Alignment: act0, hs0 and vs0 pass through a PIX_LAT-deep shift register. The delayed act flag selects the colour, and the colour plus the delayed sync flags are registered once more.
  - Result: video_on, hs, vs and RGB all appear PIX_LAT+1 cycles after the corresponding x_pos/y_pos.
  - The pixel_data sampled at that final register is the one returned for those coordinates.
- Colour: video_on stage true -> vga_r=pixel_data[3:0], vga_g=pixel_data[7:4], vga_b=pixel_data[11:8]. Otherwise all zero, regardless of pixel_data.
- No arithmetic beyond the 10-bit counters; compares are unsigned.
- Reset (values held while vga_rst=1):
  - Counters, x_pos, y_pos = 0.
  - All delay stages cleared to: act=0, hs=1, vs=1.
  - video_on=0, hs=1, vs=1, RGB=0, frame_start=0.
  - First cycle after release: x_pos=0, y_pos=0, frame_start=1.
  - Reset asserted mid-frame takes effect at the next edge. No partial line completes, and pipeline contents are discarded, not flushed.
- Simultaneous h and v wrap: handled in the same edge; no extra cycle is inserted.
- Every output is a flop output; no combinational path from pixel_data to pins.

Test Plan:
- Reset: hold vga_rst 3 cycles with pixel_data=12'hFFF -> hs=1, vs=1, video_on=0, RGB=0, x_pos=y_pos=0. First cycle after release -> frame_start=1.
- Line/frame timing, PIX_LAT=1:
  - hs falls 2 cycles after x_pos=656 and stays low exactly 96 cycles; period 800 cycles.
  - vs low exactly 1600 cycles per frame.
  - frame_start period 420000 cycles.
  - video_on high 640 cycles/line on 480 lines.
- Colour mapping: pixel_data=12'h3A5 held -> during active, vga_r=5, vga_g=A, vga_b=3. During blanking with pixel_data still 12'h3A5 -> RGB=0.
- Alignment: source returns pixel_data={2'b0,x_pos} delayed PIX_LAT cycles. With PIX_LAT=1 and PIX_LAT=3 -> first active RGB cycle of each line carries x=0, last carries x=639; video_on edges coincide.
- Wrap: observe x_pos=799, y_pos=524 -> next cycle x_pos=0, y_pos=0, frame_start=1.
- Mid-frame reset: assert vga_rst one cycle at x_pos=300, y_pos=200 -> next cycle all outputs at reset values. After release, counting restarts from (0,0) with frame_start=1.
